// File: rtl/serial_to_parallel_rx_if.sv
// Serial lane and byte-rate outputs of the serial-to-parallel receiver.
// The transmit/consumer side uses master; the receiver uses slave.
interface serial_to_parallel_rx_if #(
    parameter int WIDTH = 8
);
    logic             data_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active
    );
endinterface

// File: rtl/serial_to_parallel_rx.sv
// MSB-first 1-bit to WIDTH-bit deserializer on clk_8f with comma-run lock detection.
//   state  | meaning
//   SEARCH | counting consecutive commas; outputs held at zero
//   ACTIVE | locked; non-comma bytes presented with valid_out for one byte period
module serial_to_parallel_rx #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
    parameter int               LOCK_COUNT = 4
) (
    input logic                    clk_8f,
    input logic                    reset,
    serial_to_parallel_rx_if.slave rx
);
    localparam int            CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [2:0]    LOCK_CNT = 3'(LOCK_COUNT);

    typedef enum logic {
        SEARCH,
        ACTIVE
    } state_t;

    state_t           state;
    // Only the low WIDTH-1 bits of the shifter are ever consumed; the MSB of a
    // byte comes from sr while its LSB is taken straight from data_in.
    logic [WIDTH-2:0] sr;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bc_cnt;
    logic [WIDTH-1:0] rx_byte;
    logic             byte_done;

    assign rx_byte   = {sr, rx.data_in};
    assign byte_done = (cnt == LAST_BIT);

    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            state        <= SEARCH;
            sr           <= '0;
            cnt          <= '0;
            bc_cnt       <= '0;
            rx.data_out  <= '0;
            rx.valid_out <= 1'b0;
            rx.active    <= 1'b0;
        end else begin
            sr  <= rx_byte[WIDTH-2:0];
            cnt <= cnt + 1'b1;
            if (byte_done) begin
                case (state)
                    SEARCH: begin
                        if (rx_byte == COMMA) begin
                            if (bc_cnt + 3'd1 >= LOCK_CNT) begin
                                bc_cnt    <= LOCK_CNT;
                                state     <= ACTIVE;
                                rx.active <= 1'b1;
                            end else begin
                                bc_cnt <= bc_cnt + 3'd1;
                            end
                        end else begin
                            bc_cnt <= '0;
                        end
                    end
                    ACTIVE: begin
                        if (rx_byte != COMMA) begin
                            rx.data_out  <= rx_byte;
                            rx.valid_out <= 1'b1;
                        end else begin
                            rx.valid_out <= 1'b0;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Scoreboard bench for serial_to_parallel_rx: a byte-level model queues the expected
// outputs per byte; a monitor pops them on each byte-complete edge and checks every edge.
module tb_serial_to_parallel_rx;
    localparam logic [7:0] BC = 8'hBC;

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       active;
    } exp_t;

    logic clk_8f;
    logic reset;
    serial_to_parallel_rx_if #(.WIDTH(8)) rx_if ();

    serial_to_parallel_rx #(.WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(4)) dut (
        .clk_8f(clk_8f),
        .reset (reset),
        .rx    (rx_if.slave)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t cur_exp;
    int   edge_cnt = 0;

    // model state
    logic       m_active;
    int         m_bc;
    logic [7:0] m_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial begin
        clk_8f = 1'b0;
        forever #5 clk_8f = ~clk_8f;
    end

    always @(posedge clk_8f) begin
        #1;
        if (!reset) begin
            edge_cnt = 0;
            cur_exp  = '{data: 8'h00, valid: 1'b0, active: 1'b0};
        end else begin
            edge_cnt++;
            if (edge_cnt % 8 == 0) begin
                check("sb_avail", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) cur_exp = sb_q.pop_front();
            end
        end
        check("data_out", 32'(rx_if.data_out), 32'(cur_exp.data));
        check("valid_out", 32'(rx_if.valid_out), 32'(cur_exp.valid));
        check("active", 32'(rx_if.active), 32'(cur_exp.active));
    end

    task automatic model_reset();
        sb_q.delete();
        m_active = 1'b0;
        m_bc     = 0;
        m_data   = 8'h00;
    endtask

    // Starts and ends on a falling edge; reset is released there so the next rising edge is edge 1.
    task automatic do_reset();
        @(negedge clk_8f);
        reset = 1'b0;
        rx_if.data_in = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_8f);
        reset = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_t e;
        if (!m_active) begin
            if (b == BC) begin
                m_bc++;
                if (m_bc >= 4) m_active = 1'b1;
            end else begin
                m_bc = 0;
            end
            e = '{data: m_data, valid: 1'b0, active: m_active};
        end else if (b != BC) begin
            m_data = b;
            e = '{data: m_data, valid: 1'b1, active: 1'b1};
        end else begin
            e = '{data: m_data, valid: 1'b0, active: 1'b1};
        end
        sb_q.push_back(e);
        for (int i = 7; i >= 0; i--) begin
            rx_if.data_in = b[i];
            @(posedge clk_8f);
            @(negedge clk_8f);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] seq_a [11];
        logic [7:0] seq_b [9];
        logic [7:0] partial;
        seq_a = '{BC, BC, BC, BC, 8'hA5, 8'h3C, 8'h5A, BC, 8'hFF, 8'h00, 8'hFF};
        seq_b = '{BC, BC, BC, 8'h00, BC, BC, BC, BC, 8'h77};

        reset = 1'b0;
        rx_if.data_in = 1'b0;
        model_reset();
        #1;
        check("rst_data", 32'(rx_if.data_out), 0);
        check("rst_valid", 32'(rx_if.valid_out), 0);
        check("rst_active", 32'(rx_if.active), 0);

        // lock, data words, comma gap, FF/00/FF, then valid word before a mid-byte reset
        do_reset();
        foreach (seq_a[i]) send_byte(seq_a[i]);
        send_byte(8'hC3);

        partial = 8'h12;
        for (int i = 7; i >= 5; i--) begin
            rx_if.data_in = partial[i];
            @(posedge clk_8f);
            @(negedge clk_8f);
        end
        check("pre_rst_valid", 32'(rx_if.valid_out), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_data", 32'(rx_if.data_out), 0);
        check("async_valid", 32'(rx_if.valid_out), 0);
        check("async_active", 32'(rx_if.active), 0);
        model_reset();
        @(negedge clk_8f);
        @(negedge clk_8f);
        reset = 1'b1;

        // relock from release, then one data word
        repeat (4) send_byte(BC);
        send_byte(8'h81);

        // broken comma run delays lock to edge 64
        do_reset();
        foreach (seq_b[i]) send_byte(seq_b[i]);
        send_byte(BC);
        send_byte(8'h01);

        @(negedge clk_8f);
        check("sb_drain", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
